// File: rtl/fetch_pc_unit.sv
// PC/IR/MDR/ALUOut register stage of the multicycle MIPS datapath: next-PC select, beq/bne
// resolution, IorD address mux. Define PERF_CNT_EN to build the fetch/taken-branch counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write_i,
  input  logic             pc_write_cond_i,
  input  logic [1:0]       pc_src_i,
  input  logic             ir_write_i,
  input  logic             iord_i,
  input  logic             zero_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      reg_a_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instruction_o,
  output logic [31:0]      mdr_o,
  output logic [31:0]      alu_out_o,
  output logic [31:0]      mem_addr_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] br_taken_cnt_o
);

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcJump   = 2'b01,
    PcSrcAluOut = 2'b10,
    PcSrcRegA   = 2'b11
  } pc_src_e;

  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q;
  logic [31:0] alu_out_q;
  logic        misalign_q, misalign_d;

  logic [5:0]  opcode;
  logic        take;
  logic        pc_load;
  logic        br_taken;
  logic [31:0] jump_target;
  logic [31:0] npc;

  // Branch decode always uses the IR contents before this edge.
  always_comb begin
    opcode = ir_q[31:26];
    take   = 1'b0;
    if (opcode == OpBeq) begin
      take = zero_i;
    end else if (opcode == OpBne) begin
      take = ~zero_i;
    end
  end

  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign pc_load     = pc_write_i | (pc_write_cond_i & take);
  assign br_taken    = pc_write_cond_i & take & ~pc_write_i;

  always_comb begin
    npc = alu_result_i;
    unique case (pc_src_e'(pc_src_i))
      PcSrcAlu:    npc = alu_result_i;
      PcSrcJump:   npc = jump_target;
      PcSrcAluOut: npc = alu_out_q;
      PcSrcRegA:   npc = reg_a_i;
      default:     npc = alu_result_i;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    ir_d       = ir_q;
    if (pc_load) begin
      pc_d = {npc[31:2], 2'b00};
      if (npc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
    if (ir_write_i) begin
      ir_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      mdr_q      <= 32'h0;
      alu_out_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mem_rdata_i;
      alu_out_q  <= alu_result_i;
      misalign_q <= misalign_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

  // Free-running modulo counters; wrap is intentional.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    br_cnt_d    = br_cnt_q;
    if (ir_write_i) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
    if (br_taken) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign br_taken_cnt_o = br_cnt_q;
`else
  logic unused_br_taken;
  assign unused_br_taken = br_taken;
  assign fetch_cnt_o     = '0;
  assign br_taken_cnt_o  = '0;
`endif

  assign pc_o          = pc_q;
  assign instruction_o = ir_q;
  assign mdr_o         = mdr_q;
  assign alu_out_o     = alu_out_q;
  assign misalign_o    = misalign_q;
  assign mem_addr_o    = iord_i ? alu_out_q : pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed spec scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

  localparam int unsigned CNT_W    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0, pc_write_cond = 1'b0, ir_write = 1'b0, iord = 1'b0, zero = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] alu_result = 32'h0, reg_a = 32'h0, mem_rdata = 32'h0;

  logic [31:0]      pc, instruction, mdr, alu_out, mem_addr;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt, br_taken_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_ir, m_mdr, m_alu_out;
  logic        m_mis;
  logic [31:0] m_fetch, m_br;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write_i      (pc_write),
    .pc_write_cond_i (pc_write_cond),
    .pc_src_i        (pc_src),
    .ir_write_i      (ir_write),
    .iord_i          (iord),
    .zero_i          (zero),
    .alu_result_i    (alu_result),
    .reg_a_i         (reg_a),
    .mem_rdata_i     (mem_rdata),
    .pc_o            (pc),
    .instruction_o   (instruction),
    .mdr_o           (mdr),
    .alu_out_o       (alu_out),
    .mem_addr_o      (mem_addr),
    .misalign_o      (misalign),
    .fetch_cnt_o     (fetch_cnt),
    .br_taken_cnt_o  (br_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PERF_CNT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  // Model: what each register must hold after an edge, from the datapath rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RESET_PC; m_ir <= 0; m_mdr <= 0; m_alu_out <= 0; m_mis <= 0;
      m_fetch <= 0; m_br <= 0;
    end else begin
      logic [31:0] target;
      logic        is_taken;
      int          op;
      op       = int'(m_ir >> 26);
      is_taken = (op == 4 && zero) || (op == 5 && !zero);
      case (pc_src)
        2'd0:    target = alu_result;
        2'd1:    target = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
        2'd2:    target = m_alu_out;
        default: target = reg_a;
      endcase
      if (pc_write || (pc_write_cond && is_taken)) begin
        m_pc <= target & 32'hFFFF_FFFC;
        if ((target % 4) != 0) m_mis <= 1'b1;
      end
      if (ir_write) begin
        m_ir    <= mem_rdata;
        m_fetch <= m_fetch + 1;
      end
      if (pc_write_cond && is_taken && !pc_write) m_br <= m_br + 1;
      m_mdr     <= mem_rdata;
      m_alu_out <= alu_result;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("pc", pc, m_pc);
      chk("instruction", instruction, m_ir);
      chk("mdr", mdr, m_mdr);
      chk("alu_out", alu_out, m_alu_out);
      chk("mem_addr", mem_addr, iord ? m_alu_out : m_pc);
      chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
      chk("fetch_cnt", fetch_cnt, cnt_exp(m_fetch));
      chk("br_taken_cnt", br_taken_cnt, cnt_exp(m_br));
    end
  end

  task automatic cyc(input logic pw, input logic pwc, input logic [1:0] src, input logic irw,
                     input logic io, input logic z, input logic [31:0] ar, input logic [31:0] ra,
                     input logic [31:0] rd);
    @(negedge clk); #1;
    pc_write = pw; pc_write_cond = pwc; pc_src = src; ir_write = irw; iord = io; zero = z;
    alu_result = ar; reg_a = ra; mem_rdata = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] br0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", instruction, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    @(negedge clk); rst = 1'b0; cmp_en = 1'b1;

    // Fetch: IR gets word at old PC, PC advances together
    cyc(1, 0, 2'b00, 1, 0, 0, 32'h4, 0, 32'h2008_0005);
    chk("fetch_pc", pc, 32'h4);
    chk("fetch_ir", instruction, 32'h2008_0005);

    // beq with alu_out=0x20
    cyc(0, 0, 2'b00, 1, 0, 0, 32'h20, 0, 32'h1000_0003);
    br0 = br_taken_cnt;
    cyc(0, 1, 2'b10, 0, 0, 1, 32'h99, 0, 0);
    chk("beq_taken", pc, 32'h20);
    chk("beq_cnt", br_taken_cnt, cnt_exp(br0 + 1));
    cyc(0, 1, 2'b10, 0, 0, 0, 32'h44, 0, 0);
    chk("beq_not_taken", pc, 32'h20);

    // bne
    cyc(0, 0, 2'b00, 1, 0, 0, 32'h80, 0, 32'h1400_0003);
    cyc(0, 1, 2'b10, 0, 0, 1, 32'h0, 0, 0);
    chk("bne_hold", pc, 32'h20);
    chk("bne_hold_cnt", br_taken_cnt, cnt_exp(br0 + 1));
    cyc(0, 1, 2'b10, 0, 0, 0, 32'h0, 0, 0);
    chk("bne_taken", pc, 32'h0);
    chk("bne_cnt", br_taken_cnt, cnt_exp(br0 + 2));

    // Jump
    cyc(1, 0, 2'b00, 1, 0, 0, 32'h4000_0010, 0, 32'h0800_0100);
    chk("j_setup_pc", pc, 32'h4000_0010);
    cyc(1, 0, 2'b01, 0, 0, 0, 32'h0, 0, 0);
    chk("j_pc", pc, 32'h4000_0400);

    // Misaligned jr, sticky
    cyc(1, 0, 2'b11, 0, 0, 0, 32'h0, 32'h0000_0103, 0);
    chk("jr_pc", pc, 32'h100);
    chk("jr_mis", {31'h0, misalign}, 32'h1);
    cyc(1, 0, 2'b00, 0, 0, 0, 32'h200, 0, 0);
    chk("mis_sticky", {31'h0, misalign}, 32'h1);

    // Reset mid-cycle during LW-style access
    cyc(0, 0, 2'b00, 0, 1, 0, 32'h1234_5678, 0, 32'hDEAD_BEEF);
    chk("lw_addr", mem_addr, 32'h1234_5678);
    #2 rst = 1'b1; #1;
    chk("arst_pc", pc, RESET_PC);
    chk("arst_ir", instruction, 32'h0);
    chk("arst_mdr", mdr, 32'h0);
    chk("arst_aluout", alu_out, 32'h0);
    chk("arst_mis", {31'h0, misalign}, 32'h0);
    chk("arst_fcnt", fetch_cnt, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    @(negedge clk); #1 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ar, ra, rd;
      int sel;
      ar = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) ar = $urandom;
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      rd = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) rd = {6'b000100, rd[25:0]};
      else if (sel == 1) rd = {6'b000101, rd[25:0]};
      else if (sel == 2) rd = {6'b000010, rd[25:0]};
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ar, ra, rd);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #2 rst = 1'b0;
      end
    end

    @(negedge clk); cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
